// File: rtl/oq_qdr_read_scheduler.sv
// oq_qdr_read_scheduler
// Shares the QDR read path of the output queue among output ports, one whole
// packet at a time. It works as follows:
//   - A round-robin arbiter picks one head-of-queue descriptor from the eligible ports.
//   - A port is eligible when it is enabled, has a descriptor, and holds enough
//     output-FIFO credit for the whole packet.
//   - The granted packet is emitted as one read command per 256b word, in order.
//   - Packets are never interleaved.
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   port_enable       per-port arbitration mask (1 = may be granted)
//   desc_valid        per-port head-of-queue descriptor present
//   desc_addr         per-port start word address, port i at [i*A +: A]
//   desc_words        per-port packet length in words, port i at [i*L +: L]
//   desc_ready        one-cycle pop pulse to the granted port
//   credit_return     per-port: one word drained from that port's output FIFO
//   rd_valid/rd_ready read command handshake towards the QDR controller
//   rd_addr, rd_port  word address and destination port of the command
//   rd_last           final word of the packet
//   credit_err        sticky credit-overflow flag
module oq_qdr_read_scheduler #(
  parameter int output_ports     = 7,
  parameter int addr_width       = 19,
  parameter int len_width        = 9,
  parameter int fifo_depth_words = 64,
  parameter int port_width       = 3
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [output_ports-1:0]            port_enable,
  input  logic [output_ports-1:0]            desc_valid,
  input  logic [output_ports*addr_width-1:0] desc_addr,
  input  logic [output_ports*len_width-1:0]  desc_words,
  output logic [output_ports-1:0]            desc_ready,
  input  logic [output_ports-1:0]            credit_return,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [addr_width-1:0]              rd_addr,
  output logic [port_width-1:0]              rd_port,
  output logic                               rd_last,
  output logic                               credit_err
);

  localparam int CW = $clog2(fifo_depth_words + 1);
  localparam logic [CW-1:0] DEPTH = CW'(fifo_depth_words);
  localparam logic [port_width-1:0] LAST_PORT = port_width'(output_ports - 1);

  // POP covers a zero-length descriptor: pop pulse, no command, then back to ARB.
  typedef enum logic [1:0] {ARB = 2'd0, ISSUE = 2'd1, POP = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [port_width-1:0]   rr_q, rr_d;
  logic [len_width-1:0]    cnt_q, cnt_d;
  logic [len_width-1:0]    words_q, words_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [addr_width-1:0]   rd_addr_q, rd_addr_d;
  logic [port_width-1:0]   rd_port_q, rd_port_d;
  logic                    rd_last_q, rd_last_d;
  logic [output_ports-1:0] desc_ready_q, desc_ready_d;
  logic [CW-1:0]           credit_q [output_ports];
  logic [CW-1:0]           credit_d [output_ports];
  logic                    credit_err_q, credit_err_d;

  logic [output_ports-1:0] elig_s;
  logic                    grant_found_s;
  logic                    grant_s;
  logic [port_width-1:0]   grant_idx_s;
  logic [addr_width-1:0]   g_addr_s;
  logic [len_width-1:0]    g_words_s;

  // Eligibility and round-robin search starting just after the last granted port.
  always_comb begin
    int   idx;
    logic take;
    idx           = 0;
    take          = 1'b0;
    elig_s        = {output_ports{1'b0}};
    grant_found_s = 1'b0;
    grant_idx_s   = {port_width{1'b0}};
    g_addr_s      = {addr_width{1'b0}};
    g_words_s     = {len_width{1'b0}};
    for (int i = 0; i < output_ports; i++) begin
      elig_s[i] = port_enable[i] & desc_valid[i] &
                  (32'(credit_q[i]) >= 32'(desc_words[i*len_width +: len_width]));
    end
    for (int k = 1; k <= output_ports; k++) begin
      idx           = (int'(rr_q) + k) % output_ports;
      take          = elig_s[idx] & ~grant_found_s;
      grant_idx_s   = take ? port_width'(idx) : grant_idx_s;
      g_addr_s      = take ? desc_addr[idx*addr_width +: addr_width] : g_addr_s;
      g_words_s     = take ? desc_words[idx*len_width +: len_width] : g_words_s;
      grant_found_s = grant_found_s | elig_s[idx];
    end
    grant_s = (state_q == ARB) & grant_found_s;
  end

  // Next-state and next-output logic; command outputs are registered.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    words_d      = words_q;
    rd_valid_d   = rd_valid_q;
    rd_addr_d    = rd_addr_q;
    rd_port_d    = rd_port_q;
    rd_last_d    = rd_last_q;
    desc_ready_d = {output_ports{1'b0}};
    case (state_q)
      ARB: begin
        if (grant_s) begin
          rr_d      = grant_idx_s;
          words_d   = g_words_s;
          cnt_d     = {len_width{1'b0}};
          rd_addr_d = g_addr_s;
          rd_port_d = grant_idx_s;
          for (int i = 0; i < output_ports; i++) begin
            desc_ready_d[i] = (int'(grant_idx_s) == i);
          end
          if (g_words_s == {len_width{1'b0}}) begin
            state_d = POP;
          end else begin
            state_d    = ISSUE;
            rd_valid_d = 1'b1;
            rd_last_d  = (g_words_s == len_width'(1));
          end
        end else begin
          state_d = ARB;
        end
      end
      ISSUE: begin
        if (rd_ready) begin
          if (rd_last_q) begin
            state_d    = ARB;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
          end else begin
            // Address wraps naturally modulo 2^addr_width.
            cnt_d     = cnt_q + len_width'(1);
            rd_addr_d = rd_addr_q + addr_width'(1);
            rd_last_d = ((cnt_q + len_width'(1)) == (words_q - len_width'(1)));
          end
        end else begin
          state_d = ISSUE;
        end
      end
      POP: begin
        state_d = ARB;
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // Credit accounting: grant debits, returns credit, overflow saturates and flags.
  always_comb begin
    int tmp;
    tmp          = 32'sd0;
    credit_err_d = credit_err_q;
    for (int i = 0; i < output_ports; i++) begin
      tmp = int'(credit_q[i]) + int'(credit_return[i]) -
            ((grant_s && (int'(grant_idx_s) == i)) ? int'(g_words_s) : 32'sd0);
      if (tmp > fifo_depth_words) begin
        credit_d[i]  = DEPTH;
        credit_err_d = 1'b1;
      end else begin
        credit_d[i] = CW'(tmp);
      end
    end
  end

  // State, command and credit registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB;
      rr_q         <= LAST_PORT;
      cnt_q        <= {len_width{1'b0}};
      words_q      <= {len_width{1'b0}};
      rd_valid_q   <= 1'b0;
      rd_addr_q    <= {addr_width{1'b0}};
      rd_port_q    <= {port_width{1'b0}};
      rd_last_q    <= 1'b0;
      desc_ready_q <= {output_ports{1'b0}};
      credit_err_q <= 1'b0;
      for (int i = 0; i < output_ports; i++) begin
        credit_q[i] <= DEPTH;
      end
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      words_q      <= words_d;
      rd_valid_q   <= rd_valid_d;
      rd_addr_q    <= rd_addr_d;
      rd_port_q    <= rd_port_d;
      rd_last_q    <= rd_last_d;
      desc_ready_q <= desc_ready_d;
      credit_err_q <= credit_err_d;
      for (int i = 0; i < output_ports; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign desc_ready = desc_ready_q;
  assign rd_valid   = rd_valid_q;
  assign rd_addr    = rd_addr_q;
  assign rd_port    = rd_port_q;
  assign rd_last    = rd_last_q;
  assign credit_err = credit_err_q;

endmodule
